// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART register bridge.
package uart_bridge_pkg;

    // Command opcodes as they arrive on the serial link
    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'

    // Single-byte responses pushed back to the host
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TO  = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_OP   = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_BUS_WR   = 3'd4,
        ST_BUS_RD   = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_RESP     = 3'd7
    } bridge_state_t;

endpackage

// File: rtl/uart_byte_fetch.sv
// RX FIFO pop handshake and inter-byte timeout counter.
// rd_en is issued combinationally when a byte is wanted and available; the
// byte shows up on rx_data the next cycle, flagged by byte_valid.
module uart_byte_fetch #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_en,   // FSM is in a GET_* state
    input  logic       tmo_en,     // FSM is mid-frame (GET_ADDR/GET_DATA)
    input  logic       clr,        // restart the timeout for a new frame
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_en,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       timeout
);

    // With the timeout disabled the counter still saturates, just at all-ones
    localparam logic [CNT_W-1:0] CNT_LIM =
        (TIMEOUT_CYC == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT_CYC);

    logic             pend;
    logic [CNT_W-1:0] cnt;

    assign timeout    = (TIMEOUT_CYC != 0) && (cnt >= CNT_LIM);
    // pend blocks a second pop while the previous byte is still in flight;
    // an expired frame must not swallow a byte that belongs to the next one
    assign rd_en      = fetch_en && !rx_empty && !pend && !(tmo_en && timeout);
    assign byte_valid = pend;
    assign rx_byte    = rx_data;

    // Track the in-flight pop: the FIFO presents data the cycle after rd_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= 1'b0;
        else       pend <= rd_en;
    end

    // Idle-cycle counter: cleared by every captured byte, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || pend)
            cnt <= '0;
        else if (tmo_en && rx_empty && (cnt < CNT_LIM))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Host command bridge: parses 'W'/'R' frames from the RX FIFO, performs one
// register-bus access and pushes a single response byte into the TX FIFO.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_en,
    input  logic       tx_full,
    output logic [7:0] tx_data,
    output logic       wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    bridge_state_t state;
    logic          is_wr;      // frame opcode was 'W'
    logic [7:0]    addr_q;     // write address held until the data byte lands
    logic [7:0]    resp_q;     // response byte, doubles as tx_data
    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          timeout;
    logic          fetch_en;
    logic          tmo_en;

    assign fetch_en = (state == ST_GET_OP) || (state == ST_GET_ADDR) ||
                      (state == ST_GET_DATA);
    assign tmo_en   = (state == ST_GET_ADDR) || (state == ST_GET_DATA);

    uart_byte_fetch #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .tmo_en     (tmo_en),
        .clr        (state == ST_IDLE),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_en      (rd_en),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .timeout    (timeout)
    );

    assign wr_en   = (state == ST_RESP) && !tx_full;
    assign tx_data = resp_q;
    assign busy    = (state != ST_IDLE);

    // Frame FSM; bus strobes are single-cycle pulses, address/data hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            is_wr     <= 1'b0;
            addr_q    <= '0;
            resp_q    <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_GET_OP;
                ST_GET_OP: begin
                    if (byte_valid) begin
                        if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                            is_wr <= (rx_byte == OP_WR);
                            state <= ST_GET_ADDR;
                        end else begin
                            resp_q <= RSP_ERR;
                            state  <= ST_RESP;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (byte_valid) begin
                        if (is_wr) begin
                            addr_q <= rx_byte;
                            state  <= ST_GET_DATA;
                        end else begin
                            reg_addr <= rx_byte;
                            reg_re   <= 1'b1;
                            state    <= ST_BUS_RD;
                        end
                    end else if (timeout) begin
                        resp_q <= RSP_TO;
                        state  <= ST_RESP;
                    end
                end
                ST_GET_DATA: begin
                    if (byte_valid) begin
                        reg_addr  <= addr_q;
                        reg_wdata <= rx_byte;
                        reg_we    <= 1'b1;
                        state     <= ST_BUS_WR;
                    end else if (timeout) begin
                        resp_q <= RSP_TO;
                        state  <= ST_RESP;
                    end
                end
                ST_BUS_WR: begin
                    resp_q <= RSP_OK;
                    state  <= ST_RESP;
                end
                ST_BUS_RD:  state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    resp_q <= reg_rdata;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (!tx_full) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Host-side command bridge at the FIFO end of the UART top level: pops received bytes from the RX FIFO, parses 2- or 3-byte command frames, and performs one single-beat access on an 8-bit register bus. It then pushes a 1-byte response into the TX FIFO. It is the reader of the RX FIFO and the writer of the TX FIFO, giving an external host register access over the serial link.

## Interface
- TIMEOUT_CYC, 4096: idle cycles allowed between bytes of one frame; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter; TIMEOUT_CYC must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  RX FIFO empty flag
- rx_data  in  8  RX FIFO read data; valid the cycle after an rd_en pulse
- rd_en  out  1  RX FIFO pop strobe, one cycle per byte
- tx_full  in  1  TX FIFO full flag
- tx_data  out  8  TX FIFO write data, valid while wr_en=1
- wr_en  out  1  TX FIFO push strobe, one cycle per byte
- reg_addr  out  8  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  write strobe, one cycle
- reg_re  out  1  read strobe, one cycle
- reg_rdata  in  8  read data; valid the cycle after reg_re
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Frames:
  - Write: 0x57 'W', addr, data. Response 0x4B 'K'.
  - Read: 0x52 'R', addr. Response is the read byte.
  - Any other opcode byte: response 0x45 'E'. No bus access; that byte alone is consumed.
- FSM states and transitions:
  - IDLE → GET_OP.
  - GET_OP → GET_ADDR on a valid opcode, else RESP with 'E'.
  - GET_ADDR → BUS_RD for 'R', GET_DATA for 'W'.
  - GET_DATA → BUS_WR.
  - BUS_WR → RESP.
  - BUS_RD → RD_WAIT → RESP.
  - RESP → IDLE once the byte is pushed.
- Byte fetch in every GET_* state:
  - rd_en pulses only when rx_empty=0.
  - rx_data is captured on the following cycle.
  - Next fetch no earlier than the cycle after the capture.
  - rd_en is never high on two consecutive cycles.
- RESP: holds tx_data and waits while tx_full=1; wr_en is never asserted with tx_full=1.
- Timeout:
  - Counter clears on each captured byte.
  - Increments each cycle spent in GET_ADDR/GET_DATA with rx_empty=1.
  - When it reaches TIMEOUT_CYC: frame aborted, no bus access, RESP with 0x54 'T'.
  - The counter saturates and never wraps.
- Read data: reg_rdata captured in RD_WAIT, without modification.
- Reset: all outputs 0, FSM IDLE, counter 0.
  - Reset mid-frame discards the partial frame.
  - No response byte is emitted for a discarded frame.

## Timing
- Fetch latency: rx_empty low in GET_* at cycle t → rd_en at t → byte captured at t+1 → next state at t+2.
- Write frame, last byte captured at cycle c:
  - reg_we, reg_addr, reg_wdata at c+1.
  - wr_en with 0x4B at c+2 if tx_full=0.
- Read frame, addr captured at cycle c:
  - reg_re at c+1.
  - reg_rdata sampled at c+2.
  - wr_en with the data at c+3 if tx_full=0.
- reg_addr and reg_wdata hold their last values between accesses. reg_we and reg_re are never high together.
- busy rises the cycle after IDLE exits and falls the cycle after the response wr_en.
- A new frame is not fetched until the previous response is pushed. Back-to-back frames are fully serialized.

## Structure
- Package uart_bridge_pkg holds:
  - opcode constants OP_WR=8'h57, OP_RD=8'h52
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_TO=8'h54
  - state enum typedef bridge_state_t
- One sub-module, uart_byte_fetch: the rd_en/capture handshake plus the timeout counter.
  - Outputs byte_valid, byte and timeout to the main FSM.
- Top FSM, bus strobes and response mux live in uart_reg_bridge.

## Test plan
- Write 'W',0x10,0xA5 with a FIFO model → single reg_we with addr 0x10 / wdata 0xA5; TX receives 0x4B.
- Bus model returns 0x3C at 0x22; read 'R',0x22 → single reg_re at 0x22; TX receives 0x3C; no reg_we.
- Opcode 0x00 then a valid 'R',0x01 → TX receives 0x45 then the read data; exactly 3 rd_en pulses.
- TIMEOUT_CYC=16; send 'W',0x05 then stall the RX FIFO → TX receives 0x54 after 16 empty cycles; no reg_we; busy falls.
- Hold tx_full=1 for 50 cycles during RESP → wr_en stays 0, tx_data stable; single push after release.
- Assert reset after 'W',0x07 is received → outputs 0, no TX byte; next complete frame executes normally.
